// File: rtl/seven_segment_scan.sv
// Time-multiplexed, double-buffered driver for an N-digit common-anode
// seven-segment display with per-digit blanking and decimal points.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   load_i            strobe: capture data_i / dp_i / digit_en_i as pending
//   data_i            hex nibbles, digit k = data_i[4k+3:4k], digit 0 rightmost
//   dp_i              decimal point request per digit (1 = lit)
//   digit_en_i        per-digit enable (0 = digit blanked)
//   load_ack_o        one-cycle pulse when buffered data becomes active
//   frame_o           one-cycle pulse each time the scan wraps to digit 0
//   segment           active-low segments, bit0 = a ... bit6 = g
//   dp_o              active-low decimal point
//   anode             active-low digit select, at most one bit low

module seven_segment_scan #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    output logic                    load_ack_o,
    output logic                    frame_o,
    output logic [6:0]              segment,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   anode
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            4'hF: return 7'h0E;
        endcase
    endfunction

    // scan position
    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          slot_end;
    logic          wrap;

    // pending (written by load_i) and active (displayed) buffers
    logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;

    // registered outputs
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  ack_q, ack_d;
    logic                  frame_q, frame_d;

    logic       in_blank;
    logic [3:0] cur_nib;
    logic       cur_en;
    logic       cur_dp;
    logic       lit;

    // anti-ghosting: all anodes off at the start of each slot
    if (BLANK_CYCLES > 0) begin : g_blank
        assign in_blank = (presc_q < PW'(BLANK_CYCLES));
    end else begin : g_noblank
        assign in_blank = 1'b0;
    end

    always_comb begin
        slot_end = (presc_q == P_LAST);
        wrap     = slot_end && (idx_q == I_LAST);
        presc_d  = slot_end ? '0 : presc_q + PW'(1);
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == I_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // Active only changes on the wrap edge; a load on that very cycle
    // bypasses the pending buffer so it shows in the next frame's first slot.
    always_comb begin
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_en_d   = pend_en_q;
        pend_vld_d  = pend_vld_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_en_d    = act_en_q;
        ack_d       = 1'b0;
        frame_d     = wrap;
        if (wrap) begin
            if (load_i) begin
                act_data_d = data_i;
                act_dp_d   = dp_i;
                act_en_d   = digit_en_i;
                ack_d      = 1'b1;
            end else if (pend_vld_q) begin
                act_data_d = pend_data_q;
                act_dp_d   = pend_dp_q;
                act_en_d   = pend_en_q;
                ack_d      = 1'b1;
            end
            pend_vld_d = 1'b0;
        end else if (load_i) begin
            pend_data_d = data_i;
            pend_dp_d   = dp_i;
            pend_en_d   = digit_en_i;
            pend_vld_d  = 1'b1;
        end
    end

    always_comb begin
        cur_nib = '0;
        cur_en  = 1'b0;
        cur_dp  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib = act_data_q[4*k +: 4];
                cur_en  = act_en_q[k];
                cur_dp  = act_dp_q[k];
            end
        end
        lit     = cur_en && !in_blank;
        seg_d   = lit ? hex7(cur_nib) : 7'h7F;
        dp_d    = lit ? ~cur_dp : 1'b1;
        anode_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (lit && (idx_q == IW'(k))) begin
                anode_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pend_en_q   <= '0;
            pend_vld_q  <= 1'b0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_en_q    <= '0;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            anode_q     <= '1;
            ack_q       <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_en_q   <= pend_en_d;
            pend_vld_q  <= pend_vld_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_en_q    <= act_en_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            anode_q     <= anode_d;
            ack_q       <= ack_d;
            frame_q     <= frame_d;
        end
    end

    assign segment    = seg_q;
    assign dp_o       = dp_q;
    assign anode      = anode_q;
    assign load_ack_o = ack_q;
    assign frame_o    = frame_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Self-checking bench for seven_segment_scan: three instances with
// different parameters, directed vector tables plus a random-stimulus model.

module tb_seven_segment_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam int ND[3]  = '{4, 1, 4};
    localparam int DIV[3] = '{4, 3, 4};
    localparam int BL[3]  = '{0, 0, 1};

    localparam logic [6:0] HEX[16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [31:0] din[3];
    logic [7:0]  dpin[3];
    logic [7:0]  enin[3];
    logic        ld[3];
    logic        rs[3];

    logic [3:0] an_a, an_c;
    logic [0:0] an_b;
    logic [6:0] seg_a, seg_b, seg_c;
    logic       dp_a, dp_b, dp_c;
    logic       ack_a, ack_b, ack_c;
    logic       fr_a, fr_b, fr_c;

    seven_segment_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(0)) u_a (
        .clk(clk), .rst(rs[0]), .load_i(ld[0]),
        .data_i(din[0][15:0]), .dp_i(dpin[0][3:0]), .digit_en_i(enin[0][3:0]),
        .load_ack_o(ack_a), .frame_o(fr_a), .segment(seg_a), .dp_o(dp_a),
        .anode(an_a)
    );

    seven_segment_scan #(.NUM_DIGITS(1), .REFRESH_DIV(3), .BLANK_CYCLES(0)) u_b (
        .clk(clk), .rst(rs[1]), .load_i(ld[1]),
        .data_i(din[1][3:0]), .dp_i(dpin[1][0:0]), .digit_en_i(enin[1][0:0]),
        .load_ack_o(ack_b), .frame_o(fr_b), .segment(seg_b), .dp_o(dp_b),
        .anode(an_b)
    );

    seven_segment_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) u_c (
        .clk(clk), .rst(rs[2]), .load_i(ld[2]),
        .data_i(din[2][15:0]), .dp_i(dpin[2][3:0]), .digit_en_i(enin[2][3:0]),
        .load_ack_o(ack_c), .frame_o(fr_c), .segment(seg_c), .dp_o(dp_c),
        .anode(an_c)
    );

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {anode(8, zero-extended), segment, dp, ack, frame}
    function automatic logic [17:0] actual(input int i);
        case (i)
            0:       return {4'h0, an_a, seg_a, dp_a, ack_a, fr_a};
            1:       return {7'h0, an_b, seg_b, dp_b, ack_b, fr_b};
            default: return {4'h0, an_c, seg_c, dp_c, ack_c, fr_c};
        endcase
    endfunction

    // reference model: scan position is derived from elapsed cycles
    int          mt[3];
    logic [31:0] m_ad[3], m_pd[3];
    logic [7:0]  m_adp[3], m_aen[3], m_pdp[3], m_pen[3];
    bit          m_pv[3];
    logic [17:0] m_exp[3];

    task automatic model_reset(input int i);
        logic [7:0] msk;
        msk      = 8'((1 << ND[i]) - 1);
        m_exp[i] = {msk, 7'h7F, 1'b1, 1'b0, 1'b0};
        mt[i]    = 0;
        m_ad[i]  = '0;
        m_adp[i] = '0;
        m_aen[i] = '0;
        m_pd[i]  = '0;
        m_pdp[i] = '0;
        m_pen[i] = '0;
        m_pv[i]  = 1'b0;
    endtask

    task automatic model_step(input int i);
        int         p, k;
        bit         wrap;
        logic [7:0] msk, an;
        logic [6:0] sg;
        logic       d;
        if (rs[i]) begin
            model_reset(i);
        end else begin
            msk  = 8'((1 << ND[i]) - 1);
            p    = mt[i] % DIV[i];
            k    = (mt[i] / DIV[i]) % ND[i];
            wrap = (p == DIV[i] - 1) && (k == ND[i] - 1);
            an   = msk;
            sg   = 7'h7F;
            d    = 1'b1;
            if (p >= BL[i] && m_aen[i][k]) begin
                an = msk & ~(8'd1 << k);
                sg = HEX[m_ad[i][4*k +: 4]];
                d  = ~m_adp[i][k];
            end
            m_exp[i] = {an, sg, d, wrap && (ld[i] || m_pv[i]), wrap};
            if (wrap) begin
                if (ld[i]) begin
                    m_ad[i]  = din[i];
                    m_adp[i] = dpin[i];
                    m_aen[i] = enin[i];
                end else if (m_pv[i]) begin
                    m_ad[i]  = m_pd[i];
                    m_adp[i] = m_pdp[i];
                    m_aen[i] = m_pen[i];
                end
                m_pv[i] = 1'b0;
            end else if (ld[i]) begin
                m_pd[i]  = din[i];
                m_pdp[i] = dpin[i];
                m_pen[i] = enin[i];
                m_pv[i]  = 1'b1;
            end
            mt[i]++;
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_u%0d", i), 32'(actual(i)), 32'(m_exp[i]));
            model_step(i);
        end
    end

    task automatic wait_pulse(input int i, input bit use_frame, output bit found);
        logic [17:0] v;
        found = 1'b0;
        for (int c = 0; c < 48 && !found; c++) begin
            @(negedge clk);
            v = actual(i);
            if (use_frame ? v[0] : v[1]) found = 1'b1;
            tick();
        end
    endtask

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } hex_vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
    } scan_vec_t;

    hex_vec_t  hv[16];
    scan_vec_t sv[4];

    initial begin
        bit          found, armed, capd;
        int          acks, p, k;
        logic [6:0]  cap, eseg;
        logic [3:0]  ean;
        logic        edp, lit;
        logic [15:0] w;

        hv[0]  = '{4'h0, 7'h40}; hv[1]  = '{4'h1, 7'h79};
        hv[2]  = '{4'h2, 7'h24}; hv[3]  = '{4'h3, 7'h30};
        hv[4]  = '{4'h4, 7'h19}; hv[5]  = '{4'h5, 7'h12};
        hv[6]  = '{4'h6, 7'h02}; hv[7]  = '{4'h7, 7'h78};
        hv[8]  = '{4'h8, 7'h00}; hv[9]  = '{4'h9, 7'h10};
        hv[10] = '{4'hA, 7'h08}; hv[11] = '{4'hB, 7'h03};
        hv[12] = '{4'hC, 7'h46}; hv[13] = '{4'hD, 7'h21};
        hv[14] = '{4'hE, 7'h06}; hv[15] = '{4'hF, 7'h0E};
        sv[0]  = '{4'hE, 7'h40}; sv[1]  = '{4'hD, 7'h79};
        sv[2]  = '{4'hB, 7'h24}; sv[3]  = '{4'h7, 7'h30};

        for (int i = 0; i < 3; i++) begin
            rs[i]   = 1'b1;
            ld[i]   = 1'b0;
            din[i]  = '0;
            dpin[i] = '0;
            enin[i] = '0;
            model_reset(i);
        end
        tick();
        tick();
        tick();
        for (int i = 0; i < 3; i++) rs[i] = 1'b0;

        @(negedge clk);
        chk("reset_out", {an_a, seg_a, dp_a, ack_a, fr_a},
            {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
        tick();

        // scan order and latency
        din[0] = 32'h3210; enin[0] = 8'h0F; dpin[0] = 8'h00; ld[0] = 1'b1;
        tick();
        ld[0] = 1'b0;
        wait_pulse(0, 1'b0, found);
        chk("scan_ack_seen", 32'(found), 32'd1);
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            k = ((j - 1) / 4) % 4;
            chk("scan", {an_a, seg_a, fr_a}, {sv[k].an, sv[k].seg, 1'(j % 16 == 0)});
            tick();
        end

        // full hex map on the single-digit instance
        for (int n = 0; n < 16; n++) begin
            din[1] = {28'h0, hv[n].nib}; enin[1] = 8'h01; dpin[1] = 8'h00;
            ld[1] = 1'b1;
            tick();
            ld[1] = 1'b0;
            acks = 0; armed = 1'b0; capd = 1'b0; cap = 7'h7F;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (armed && !capd) begin
                    cap  = seg_b;
                    capd = 1'b1;
                end
                if (ack_b) begin
                    acks++;
                    armed = 1'b1;
                end
                tick();
            end
            chk($sformatf("hex_seg_%0h", hv[n].nib), 32'(cap), 32'(hv[n].seg));
            chk("hex_ack_count", acks, 1);
        end

        // blanking interval, digit enables and decimal points
        din[2] = 32'h3210; enin[2] = 8'h0A; dpin[2] = 8'h02; ld[2] = 1'b1;
        tick();
        ld[2] = 1'b0;
        wait_pulse(2, 1'b0, found);
        chk("blank_ack_seen", 32'(found), 32'd1);
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            p    = (j - 1) % 4;
            k    = ((j - 1) / 4) % 4;
            lit  = (k == 1 || k == 3) && (p != 0);
            ean  = lit ? (4'hF & ~(4'h1 << k)) : 4'hF;
            eseg = lit ? HEX[k] : 7'h7F;
            edp  = !(lit && k == 1);
            chk("blank_out", {an_c, seg_c, dp_c}, {ean, eseg, edp});
            tick();
        end

        // frame-boundary buffering: last load wins, wrap-cycle load bypasses
        wait_pulse(0, 1'b1, found);
        chk("buf_frame_seen", 32'(found), 32'd1);
        for (int j = 1; j <= 52; j++) begin
            ld[0]   = (j == 3 || j == 8 || j == 47);
            din[0]  = (j == 3) ? 32'hAAAA : (j == 8) ? 32'h5555 : 32'h9876;
            enin[0] = 8'h0F;
            dpin[0] = 8'h00;
            @(negedge clk);
            k    = ((j - 1) / 4) % 4;
            w    = (j <= 16) ? 16'h3210 : (j <= 48) ? 16'h5555 : 16'h9876;
            eseg = HEX[w[4*k +: 4]];
            chk("buf_out", {an_a, seg_a, ack_a},
                {4'hF & ~(4'h1 << k), eseg, 1'(j == 16 || j == 48)});
            tick();
        end
        ld[0] = 1'b0;

        // reset in slot 2 with a pending load
        wait_pulse(0, 1'b1, found);
        chk("rst_frame_seen", 32'(found), 32'd1);
        for (int j = 1; j <= 45; j++) begin
            ld[0]  = (j == 6);
            din[0] = 32'h1111;
            rs[0]  = (j == 10);
            @(negedge clk);
            if (j >= 11) begin
                chk("rst_dark", {an_a, seg_a, dp_a, ack_a}, {4'hF, 7'h7F, 1'b1, 1'b0});
            end
            chk("rst_frame", 32'(fr_a), 32'(j == 27 || j == 43));
            tick();
        end
        rs[0] = 1'b0;
        ld[0] = 1'b0;

        // random traffic on all instances against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                rs[i]   = ($urandom % 150 == 0);
                ld[i]   = ($urandom % 6 == 0);
                din[i]  = $urandom;
                dpin[i] = 8'($urandom);
                enin[i] = 8'($urandom);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            rs[i] = 1'b0;
            ld[i] = 1'b0;
        end
        tick();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
